// File: rtl/ltc26x0_pkg.sv
// Shared types and constants for the LTC26x0 queued SPI writer.
// Command codes follow the LTC2600/2610/2620 datasheet.
package ltc26x0_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD,
        ST_SCK_HI,
        ST_SCK_LO,
        ST_GAP,
        ST_CLEAR
    } ltc_state_t;

    localparam logic [3:0] CMD_WRITE         = 4'h0;
    localparam logic [3:0] CMD_UPDATE        = 4'h1;
    localparam logic [3:0] CMD_WRITE_UPD_ALL = 4'h2;
    localparam logic [3:0] CMD_WRITE_UPD     = 4'h3;
    localparam logic [3:0] CMD_PWRDN         = 4'h4;
    localparam logic [3:0] CMD_NOP           = 4'hF;

    localparam logic [3:0] ADDR_ALL = 4'hF;

    localparam int FRAME_BITS = 24;

endpackage

// File: rtl/ltc26x0_cmd_fifo.sv
// Command FIFO for the LTC26x0 writer: registered pointers and level,
// push gated by full, pop gated by empty, simultaneous push/pop allowed.
module ltc26x0_cmd_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Pointers are exactly AW bits wide, so they wrap modulo DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                level <= level + 1'b1;
            else if (!do_push && do_pop)
                level <= level - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/ltc26x0_queued_writer.sv
// Queued SPI write engine for the LTC2600/2610/2620 DACs: command FIFO,
// 24-bit frame serialiser with programmable SCK/CSB timing and CLR sequencer.
module ltc26x0_queued_writer
    import ltc26x0_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int SCK_DIV    = 2,
    parameter int CS_GAP     = 2,
    parameter int CLR_CYCLES = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [3:0]                    command,
    input  logic [3:0]                    address,
    input  logic [DATA_WIDTH-1:0]         data,
    input  logic                          clr_req,
    output logic                          sck,
    output logic                          sdi,
    output logic                          csb,
    output logic                          clrb,
    output logic                          busy,
    output logic                          write_complete,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    if (DATA_WIDTH != 16 && DATA_WIDTH != 14 && DATA_WIDTH != 12) begin : g_bad_dw
        $error("DATA_WIDTH must be 16, 14 or 12");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two >= 2");
    end
    if (SCK_DIV < 1 || CS_GAP < 1 || CLR_CYCLES < 1) begin : g_bad_timing
        $error("SCK_DIV, CS_GAP and CLR_CYCLES must be >= 1");
    end

    localparam int EW    = 8 + DATA_WIDTH;
    localparam int PAD   = 16 - DATA_WIDTH;
    localparam int CMAX0 = (SCK_DIV > CS_GAP) ? SCK_DIV : CS_GAP;
    localparam int CMAX  = (CMAX0 > CLR_CYCLES) ? CMAX0 : CLR_CYCLES;
    localparam int CW    = $clog2(CMAX + 1);

    localparam logic [CW-1:0] DIV_LAST = CW'(SCK_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(CS_GAP - 1);
    localparam logic [CW-1:0] CLR_LAST = CW'(CLR_CYCLES - 1);
    localparam logic [4:0]    BIT_LAST = 5'(FRAME_BITS - 1);

    ltc_state_t state;
    ltc_state_t state_n;

    logic [CW-1:0]          cnt;
    logic [4:0]             bit_cnt;
    logic [FRAME_BITS-1:0]  shreg;
    logic [FRAME_BITS-1:0]  frame;
    logic [EW-1:0]          head;
    logic [15:0]            data_lj;
    logic                   clr_pend;
    logic                   pop;
    logic                   take_clr;
    logic                   full;
    logic                   empty;

    ltc26x0_cmd_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_valid),
        .wdata ({command, address, data}),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    assign cmd_ready = !full;
    assign busy      = (state != ST_IDLE) || !empty || clr_pend;

    // Narrower DAC codes are left-justified in the 16-bit data field.
    assign data_lj = 16'(head[DATA_WIDTH-1:0]) << PAD;
    assign frame   = {head[EW-1 -: 8], data_lj};

    // The shift register MSB is a flop, so sdi is registered by construction.
    assign sdi = shreg[FRAME_BITS-1];

    always_comb begin
        state_n  = state;
        pop      = 1'b0;
        take_clr = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (clr_pend) begin
                    state_n  = ST_CLEAR;
                    take_clr = 1'b1;
                end else if (!empty) begin
                    state_n = ST_LEAD;
                    pop     = 1'b1;
                end
            end
            ST_LEAD: begin
                if (cnt == DIV_LAST) state_n = ST_SCK_HI;
            end
            ST_SCK_HI: begin
                if (cnt == DIV_LAST) state_n = ST_SCK_LO;
            end
            ST_SCK_LO: begin
                if (cnt == DIV_LAST)
                    state_n = (bit_cnt == BIT_LAST) ? ST_GAP : ST_SCK_HI;
            end
            ST_GAP: begin
                if (cnt == GAP_LAST) state_n = ST_IDLE;
            end
            ST_CLEAR: begin
                if (cnt == CLR_LAST) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Pin registers load from the next state so pins line up with the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            bit_cnt        <= '0;
            shreg          <= '0;
            clr_pend       <= 1'b0;
            csb            <= 1'b1;
            sck            <= 1'b0;
            clrb           <= 1'b1;
            write_complete <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= (state_n != state) ? '0 : cnt + 1'b1;

            if (pop) begin
                shreg   <= frame;
                bit_cnt <= '0;
            end else if (state == ST_SCK_HI && state_n == ST_SCK_LO) begin
                shreg <= {shreg[FRAME_BITS-2:0], 1'b0};
            end

            if (state == ST_SCK_LO && state_n == ST_SCK_HI)
                bit_cnt <= bit_cnt + 5'd1;

            clr_pend <= clr_req || (clr_pend && !take_clr);

            csb  <= !(state_n == ST_LEAD || state_n == ST_SCK_HI ||
                      state_n == ST_SCK_LO);
            sck  <= (state_n == ST_SCK_HI);
            clrb <= (state_n != ST_CLEAR);
            write_complete <= (state_n == ST_GAP) && (state != ST_GAP);
        end
    end

endmodule

// File: tb/tb_ltc26x0_queued_writer.sv
// Directed bench for ltc26x0_queued_writer: default instance plus a
// 12-bit, SCK_DIV=1 instance; frames are collected by pin monitors.
module tb_ltc26x0_queued_writer;
    import ltc26x0_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [23:0] word;
        int          low;
        int          start;
        logic        wc;
        int          per;
    } frame_t;

    // Instance A: defaults
    logic        a_valid, a_ready, a_clr;
    logic [3:0]  a_cmd, a_addr;
    logic [15:0] a_data;
    logic        a_sck, a_sdi, a_csb, a_clrb, a_busy, a_wc;
    logic [2:0]  a_level;

    // Instance B: DATA_WIDTH=12, SCK_DIV=1
    logic        b_valid, b_ready, b_clr;
    logic [3:0]  b_cmd, b_addr;
    logic [11:0] b_data;
    logic        b_sck, b_sdi, b_csb, b_clrb, b_busy, b_wc;
    logic [2:0]  b_level;

    ltc26x0_queued_writer dut_a (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid      (a_valid),
        .cmd_ready      (a_ready),
        .command        (a_cmd),
        .address        (a_addr),
        .data           (a_data),
        .clr_req        (a_clr),
        .sck            (a_sck),
        .sdi            (a_sdi),
        .csb            (a_csb),
        .clrb           (a_clrb),
        .busy           (a_busy),
        .write_complete (a_wc),
        .fifo_level     (a_level)
    );

    ltc26x0_queued_writer #(
        .DATA_WIDTH (12),
        .SCK_DIV    (1)
    ) dut_b (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid      (b_valid),
        .cmd_ready      (b_ready),
        .command        (b_cmd),
        .address        (b_addr),
        .data           (b_data),
        .clr_req        (b_clr),
        .sck            (b_sck),
        .sdi            (b_sdi),
        .csb            (b_csb),
        .clrb           (b_clrb),
        .busy           (b_busy),
        .write_complete (b_wc),
        .fifo_level     (b_level)
    );

    // Pin monitors: collect frames, clear pulses and write_complete counts
    frame_t      a_q[$];
    logic        a_in = 1'b0, a_prev_sck = 1'b0, a_prev_clrb = 1'b1;
    logic [23:0] a_word = '0;
    int          a_low = 0, a_start = 0, a_rise = 0, a_per = 0;
    int          a_wc_n = 0, a_clr_n = 0, a_clr_start = 0, a_clr_len = 0;

    always @(negedge clk) begin
        if (a_wc) a_wc_n <= a_wc_n + 1;
        a_prev_clrb <= a_clrb;
        if (!a_clrb) begin
            if (a_prev_clrb) begin
                a_clr_n     <= a_clr_n + 1;
                a_clr_start <= cyc;
                a_clr_len   <= 1;
            end else begin
                a_clr_len <= a_clr_len + 1;
            end
        end
        a_prev_sck <= a_sck;
        if (a_sck && !a_prev_sck) begin
            a_rise <= cyc;
            a_per  <= cyc - a_rise;
        end
        if (rst) begin
            a_in <= 1'b0;
        end else if (!a_csb) begin
            if (!a_in) begin
                a_in    <= 1'b1;
                a_start <= cyc;
                a_low   <= 1;
                a_word  <= '0;
            end else begin
                a_low <= a_low + 1;
                if (a_sck && !a_prev_sck) a_word <= {a_word[22:0], a_sdi};
            end
        end else if (a_in) begin
            a_in <= 1'b0;
            a_q.push_back('{a_word, a_low, a_start, a_wc, a_per});
        end
    end

    frame_t      b_q[$];
    logic        b_in = 1'b0, b_prev_sck = 1'b0;
    logic [23:0] b_word = '0;
    int          b_low = 0, b_start = 0, b_rise = 0, b_per = 0;

    always @(negedge clk) begin
        b_prev_sck <= b_sck;
        if (b_sck && !b_prev_sck) begin
            b_rise <= cyc;
            b_per  <= cyc - b_rise;
        end
        if (rst) begin
            b_in <= 1'b0;
        end else if (!b_csb) begin
            if (!b_in) begin
                b_in    <= 1'b1;
                b_start <= cyc;
                b_low   <= 1;
                b_word  <= '0;
            end else begin
                b_low <= b_low + 1;
                if (b_sck && !b_prev_sck) b_word <= {b_word[22:0], b_sdi};
            end
        end else if (b_in) begin
            b_in <= 1'b0;
            b_q.push_back('{b_word, b_low, b_start, b_wc, b_per});
        end
    end

    task automatic push_a(input logic [23:0] w);
        @(negedge clk);
        a_cmd   = w[23:20];
        a_addr  = w[19:16];
        a_data  = w[15:0];
        a_valid = 1'b1;
        @(negedge clk);
        a_valid = 1'b0;
    endtask

    task automatic push_b(input logic [3:0] c, input logic [3:0] ad,
                          input logic [11:0] d);
        @(negedge clk);
        b_cmd   = c;
        b_addr  = ad;
        b_data  = d;
        b_valid = 1'b1;
        @(negedge clk);
        b_valid = 1'b0;
    endtask

    task automatic wait_a(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (a_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_b(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (b_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_csb_low_a(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!a_csb) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [6:0] obs;
        rst = 1'b1;
        a_valid = 0; a_clr = 0; a_cmd = 0; a_addr = 0; a_data = 0;
        b_valid = 0; b_clr = 0; b_cmd = 0; b_addr = 0; b_data = 0;
        repeat (3) @(negedge clk);
        obs = {a_csb, a_sck, a_sdi, a_clrb, a_wc, a_busy, a_ready};
        checks++;
        if (obs !== 7'b1001001) begin
            errors++;
            $display("FAIL reset_pins_a: got %b expected 1001001", obs);
        end
        checks++;
        if (a_level !== 3'd0) begin
            errors++;
            $display("FAIL reset_level_a: got %0d expected 0", a_level);
        end
        obs = {b_csb, b_sck, b_sdi, b_clrb, b_wc, b_busy, b_ready};
        checks++;
        if (obs !== 7'b1001001) begin
            errors++;
            $display("FAIL reset_pins_b: got %b expected 1001001", obs);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (a_busy !== 1'b0 || a_csb !== 1'b1) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b csb=%b expected 0/1",
                     a_busy, a_csb);
        end
    endtask

    task automatic test_single_write();
        bit ok;
        int wc0;
        a_q.delete();
        wc0 = a_wc_n;
        push_a(24'h38AAAA);
        wait_a(1, 400, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL single_timeout: got no frame expected 1");
            return;
        end
        checks++;
        if (a_q[0].word !== 24'h38AAAA) begin
            errors++;
            $display("FAIL single_word: got %h expected 38aaaa", a_q[0].word);
        end
        checks++;
        if (a_q[0].low != 98) begin
            errors++;
            $display("FAIL single_csb_low: got %0d expected 98", a_q[0].low);
        end
        checks++;
        if (a_q[0].wc !== 1'b1 || a_q[0].per != 4) begin
            errors++;
            $display("FAIL single_wc_per: got wc=%b per=%0d expected 1/4",
                     a_q[0].wc, a_q[0].per);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (a_busy !== 1'b0 || a_wc_n - wc0 != 1) begin
            errors++;
            $display("FAIL single_done: got busy=%b pulses=%0d expected 0/1",
                     a_busy, a_wc_n - wc0);
        end
    endtask

    task automatic test_queue_fill();
        logic [23:0] vec [6];
        bit ok;
        vec[0] = 24'h301234;
        vec[1] = 24'h015678;
        vec[2] = 24'h329ABC;
        vec[3] = 24'h430000;
        vec[4] = 24'h2F0F0F;
        vec[5] = 24'hFFFFFF;
        a_q.delete();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a_cmd   = vec[i][23:20];
            a_addr  = vec[i][19:16];
            a_data  = vec[i][15:0];
            a_valid = 1'b1;
        end
        @(negedge clk);
        checks++;
        if (a_level !== 3'd4 || a_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill_full: got level=%0d ready=%b expected 4/0",
                     a_level, a_ready);
        end
        a_cmd  = vec[5][23:20];
        a_addr = vec[5][19:16];
        a_data = vec[5][15:0];
        repeat (2) @(negedge clk);
        a_valid = 1'b0;
        checks++;
        if (a_level !== 3'd4) begin
            errors++;
            $display("FAIL push_when_full: got level=%0d expected 4", a_level);
        end
        wait_a(1, 300, ok);
        checks++;
        if (!ok || a_ready !== 1'b0 || a_level !== 3'd4) begin
            errors++;
            $display("FAIL ready_until_pop: got ok=%b ready=%b level=%0d expected 1/0/4",
                     ok, a_ready, a_level);
        end
        wait_a(2, 300, ok);
        checks++;
        if (!ok || a_ready !== 1'b1 || a_level !== 3'd3) begin
            errors++;
            $display("FAIL after_pop: got ok=%b ready=%b level=%0d expected 1/1/3",
                     ok, a_ready, a_level);
        end
        wait_a(5, 500, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL fill_timeout: got %0d frames expected 5", a_q.size());
            return;
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (a_q[i].word !== vec[i]) begin
                errors++;
                $display("FAIL fill_word%0d: got %h expected %h",
                         i, a_q[i].word, vec[i]);
            end
        end
        for (int i = 1; i < 5; i++) begin
            checks++;
            if (a_q[i].start - a_q[i-1].start != 101) begin
                errors++;
                $display("FAIL fill_period%0d: got %0d expected 101",
                         i, a_q[i].start - a_q[i-1].start);
            end
        end
        repeat (150) @(negedge clk);
        checks++;
        if (a_q.size() != 5 || a_busy !== 1'b0) begin
            errors++;
            $display("FAIL fill_drain: got frames=%0d busy=%b expected 5/0",
                     a_q.size(), a_busy);
        end
    endtask

    task automatic test_clear();
        bit ok;
        int clr0;
        a_q.delete();
        clr0 = a_clr_n;
        @(negedge clk);
        a_cmd = CMD_WRITE_UPD; a_addr = 4'h2; a_data = 16'hC3C3; a_valid = 1'b1;
        @(negedge clk);
        a_cmd = CMD_WRITE; a_addr = ADDR_ALL; a_data = 16'h1111;
        @(negedge clk);
        a_valid = 1'b0;
        wait_csb_low_a(20, ok);
        repeat (20) @(negedge clk);
        a_clr = 1'b1;
        @(negedge clk);
        a_clr = 1'b0;
        repeat (15) @(negedge clk);
        a_clr = 1'b1;
        @(negedge clk);
        a_clr = 1'b0;
        checks++;
        if (!ok || a_csb !== 1'b0 || a_clrb !== 1'b1 || a_busy !== 1'b1) begin
            errors++;
            $display("FAIL clear_midframe: got ok=%b csb=%b clrb=%b busy=%b expected 1/0/1/1",
                     ok, a_csb, a_clrb, a_busy);
        end
        wait_a(2, 400, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL clear_timeout: got %0d frames expected 2", a_q.size());
            return;
        end
        checks++;
        if (a_q[0].word !== 24'h32C3C3 || a_q[0].low != 98) begin
            errors++;
            $display("FAIL clear_frame1: got %h/%0d expected 32c3c3/98",
                     a_q[0].word, a_q[0].low);
        end
        checks++;
        if (a_clr_n - clr0 != 1 || a_clr_len != 4) begin
            errors++;
            $display("FAIL clear_pulse: got count=%0d len=%0d expected 1/4",
                     a_clr_n - clr0, a_clr_len);
        end
        checks++;
        if (a_clr_start - (a_q[0].start + a_q[0].low) != 3) begin
            errors++;
            $display("FAIL clear_start: got %0d expected 3",
                     a_clr_start - (a_q[0].start + a_q[0].low));
        end
        checks++;
        if (a_q[1].start - a_clr_start != 5 || a_q[1].word !== 24'h0F1111) begin
            errors++;
            $display("FAIL clear_next_frame: got delay=%0d word=%h expected 5/0f1111",
                     a_q[1].start - a_clr_start, a_q[1].word);
        end
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset_midframe();
        bit ok;
        int wc0;
        logic [6:0] obs;
        a_q.delete();
        wc0 = a_wc_n;
        @(negedge clk);
        a_cmd = CMD_WRITE_UPD; a_addr = 4'h5; a_data = 16'h5A5A; a_valid = 1'b1;
        @(negedge clk);
        a_cmd = CMD_WRITE_UPD; a_addr = 4'h6; a_data = 16'h6B6B;
        @(negedge clk);
        a_valid = 1'b0;
        wait_csb_low_a(20, ok);
        repeat (42) @(negedge clk);
        checks++;
        if (!ok || a_csb !== 1'b0 || a_level !== 3'd1) begin
            errors++;
            $display("FAIL pre_reset: got ok=%b csb=%b level=%0d expected 1/0/1",
                     ok, a_csb, a_level);
        end
        #2 rst = 1'b1;
        #1;
        obs = {a_csb, a_sck, a_sdi, a_clrb, a_wc, a_busy, a_ready};
        checks++;
        if (obs !== 7'b1001001) begin
            errors++;
            $display("FAIL async_reset_pins: got %b expected 1001001", obs);
        end
        checks++;
        if (a_level !== 3'd0) begin
            errors++;
            $display("FAIL async_reset_level: got %0d expected 0", a_level);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checks++;
        if (a_q.size() != 0 || a_wc_n != wc0) begin
            errors++;
            $display("FAIL reset_no_complete: got frames=%0d pulses=%0d expected 0/0",
                     a_q.size(), a_wc_n - wc0);
        end
        push_a(24'h27BEEF);
        wait_a(1, 400, ok);
        checks++;
        if (!ok || a_q[0].word !== 24'h27BEEF || a_q[0].wc !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_frame: got ok=%b frames=%0d expected 27beef with pulse",
                     ok, a_q.size());
        end
        repeat (10) @(negedge clk);
    endtask

    task automatic test_dw12();
        bit ok;
        b_q.delete();
        push_b(CMD_WRITE, 4'h1, 12'hFFF);
        wait_b(1, 200, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL dw12_timeout: got no frame expected 1");
            return;
        end
        checks++;
        if (b_q[0].word !== 24'h01FFF0) begin
            errors++;
            $display("FAIL dw12_word: got %h expected 01fff0", b_q[0].word);
        end
        checks++;
        if (b_q[0].low != 49 || b_q[0].per != 2) begin
            errors++;
            $display("FAIL dw12_timing: got low=%0d per=%0d expected 49/2",
                     b_q[0].low, b_q[0].per);
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        bit ok;
        b_q.delete();
        @(negedge clk);
        b_cmd = CMD_WRITE_UPD; b_addr = 4'h2; b_data = 12'h123; b_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (b_level !== 3'd1) begin
            errors++;
            $display("FAIL b2b_first_push: got level=%0d expected 1", b_level);
        end
        b_cmd = CMD_WRITE_UPD; b_addr = 4'h5; b_data = 12'hABC;
        @(negedge clk);
        b_valid = 1'b0;
        checks++;
        if (b_level !== 3'd1 || b_ready !== 1'b1) begin
            errors++;
            $display("FAIL push_pop_level: got level=%0d ready=%b expected 1/1",
                     b_level, b_ready);
        end
        wait_b(2, 300, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL b2b_timeout: got %0d frames expected 2", b_q.size());
            return;
        end
        checks++;
        if (b_q[0].word !== 24'h321230 || b_q[1].word !== 24'h35ABC0) begin
            errors++;
            $display("FAIL b2b_words: got %h %h expected 321230 35abc0",
                     b_q[0].word, b_q[1].word);
        end
        checks++;
        if (b_q[1].start - b_q[0].start != 52 || b_q[1].per != 2) begin
            errors++;
            $display("FAIL b2b_timing: got period=%0d sck=%0d expected 52/2",
                     b_q[1].start - b_q[0].start, b_q[1].per);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_queue_fill();
        test_clear();
        test_reset_midframe();
        test_dw12();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
